spi_mem_target: RTL and testbench

SPI mode-0 target with an internal word memory, the responding end of the SPI command/address/data protocol issued by the existing SPI master. It decodes an 8-bit command, a 24-bit address and a 32-bit data phase, all MSB first. It commits writes to its memory or drives read data back on `miso`. It sits on the serial side of the link in the same clock domain as the master, and oversamples `sck` with `clk`.

---
 rtl/spi_mem_target_if.sv | 14 +
 rtl/spi_mem_target.sv | 146 ++++++++++++++
 tb/tb_spi_mem_target.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/spi_mem_target_if.sv
// Serial-side bundle of the SPI memory target: master drives cs/sck/mosi,
// the target answers on miso and reports status.
interface spi_mem_target_if;
  logic       cs;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       busy;
  logic       done;
  logic [7:0] lastCmd;

  modport master (output cs, sck, mosi, input miso, busy, done, lastCmd);
  modport slave  (input cs, sck, mosi, output miso, busy, done, lastCmd);
endinterface

// File: rtl/spi_mem_target.sv
// SPI mode-0 target with a small word memory: 8-bit command, 24-bit address,
// 32-bit data, MSB first, with sck oversampled by clk.
module spi_mem_target #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] READ_CMD  = 8'h03,
  parameter logic [7:0] WRITE_CMD = 8'h02
) (
  input logic             clk_i,
  input logic             rst_ni,
  spi_mem_target_if.slave bus
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, RDATA, HOLD} state_t;

  state_t         state_q;
  logic           sck_q;
  logic [4:0]     bitCnt_q;
  logic [31:0]    shiftReg_q;
  logic [31:0]    txReg_q;
  logic [AW-1:0]  addr_q;
  logic           isWrite_q;
  logic           miso_q;
  logic           done_q;
  logic [7:0]     lastCmd_q;
  logic [31:0]    mem [DEPTH];

  logic           rise;
  logic           fall;
  logic [31:0]    shift_d;
  logic           memWe;

  assign rise    = bus.sck & ~sck_q;
  assign fall    = ~bus.sck & sck_q;
  assign shift_d = {shiftReg_q[30:0], bus.mosi};

  // A chip-select rise in the same cycle as the final rise aborts the write.
  assign memWe = (state_q == WDATA) && rise && (bitCnt_q == 5'd31) && !bus.cs;

  always_ff @(posedge clk_i) begin
    if (memWe) begin
      mem[addr_q] <= shift_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      sck_q      <= 1'b0;
      bitCnt_q   <= 5'd0;
      shiftReg_q <= 32'd0;
      txReg_q    <= 32'd0;
      addr_q     <= '0;
      isWrite_q  <= 1'b0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      lastCmd_q  <= 8'h00;
    end else begin
      sck_q  <= bus.sck;
      done_q <= 1'b0;
      if (bus.cs) begin
        state_q    <= IDLE;
        bitCnt_q   <= 5'd0;
        shiftReg_q <= 32'd0;
        txReg_q    <= 32'd0;
        miso_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= CMD;
            bitCnt_q <= 5'd0;
          end
          CMD: if (rise) begin
            shiftReg_q <= shift_d;
            if (bitCnt_q == 5'd7) begin
              bitCnt_q  <= 5'd0;
              lastCmd_q <= shift_d[7:0];
              isWrite_q <= (shift_d[7:0] == WRITE_CMD);
              if ((shift_d[7:0] == READ_CMD) || (shift_d[7:0] == WRITE_CMD)) begin
                state_q <= ADDR;
              end else begin
                state_q <= HOLD;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          ADDR: if (rise) begin
            shiftReg_q <= shift_d;
            if (bitCnt_q == 5'd23) begin
              bitCnt_q <= 5'd0;
              addr_q   <= shift_d[AW-1:0];
              if (isWrite_q) begin
                state_q <= WDATA;
              end else begin
                state_q <= RDATA;
                txReg_q <= mem[shift_d[AW-1:0]];
              end
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          WDATA: if (rise) begin
            shiftReg_q <= shift_d;
            if (bitCnt_q == 5'd31) begin
              bitCnt_q <= 5'd0;
              done_q   <= 1'b1;
              state_q  <= HOLD;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          RDATA: begin
            // New bit goes out on the falling edge so it is stable at the next rise.
            if (fall) begin
              miso_q  <= txReg_q[31];
              txReg_q <= {txReg_q[30:0], 1'b0};
            end
            if (rise) begin
              if (bitCnt_q == 5'd31) begin
                bitCnt_q <= 5'd0;
                done_q   <= 1'b1;
                miso_q   <= 1'b0;
                state_q  <= HOLD;
              end else begin
                bitCnt_q <= bitCnt_q + 5'd1;
              end
            end
          end
          HOLD: begin
            miso_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.miso    = miso_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.lastCmd = lastCmd_q;

endmodule

// File: tb/tb_spi_mem_target.sv
// Directed bench for spi_mem_target: write, read-back, wrap, abort,
// unknown command and asynchronous reset mid-read.
module tb_spi_mem_target;

  logic clk;
  logic rstN;
  int   errorCount = 0;
  int   checkCount = 0;
  int   doneTotal  = 0;
  logic prevDone   = 1'b0;
  logic doubleDone = 1'b0;
  logic misoOr;

  spi_mem_target_if ifc ();

  spi_mem_target #(
    .DEPTH(16), .AW(4), .READ_CMD(8'h03), .WRITE_CMD(8'h02)
  ) dut (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts done pulses and flags any pulse that lasts longer than one cycle.
  always @(negedge clk) begin
    if (ifc.done) doneTotal <= doneTotal + 1;
    if (ifc.done && prevDone) doubleDone <= 1'b1;
    prevDone <= ifc.done;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errorCount++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic shiftBits(input logic [31:0] value, input int n,
                           output logic [31:0] captured);
    captured = 32'd0;
    for (int i = n - 1; i >= 0; i--) begin
      ifc.mosi = value[i];
      repeat (4) @(negedge clk);
      captured = {captured[30:0], ifc.miso};
      misoOr   = misoOr | ifc.miso;
      ifc.sck  = 1'b1;
      repeat (4) @(negedge clk);
      ifc.sck  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] cmd, input logic [23:0] addr,
                               input logic [31:0] data, input int nData,
                               output logic [31:0] rdata, output logic busyMid);
    logic [31:0] dummy;
    ifc.cs = 1'b0;
    repeat (3) @(negedge clk);
    shiftBits({24'd0, cmd}, 8, dummy);
    busyMid = ifc.busy;
    shiftBits({8'd0, addr}, 24, dummy);
    shiftBits(data, nData, rdata);
    repeat (3) @(negedge clk);
    ifc.cs = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rdata;
    logic [31:0] dummy;
    logic        busyMid;
    int          doneBefore;

    rstN     = 1'b0;
    ifc.cs   = 1'b1;
    ifc.sck  = 1'b0;
    ifc.mosi = 1'b0;
    misoOr   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_miso", {31'd0, ifc.miso}, 32'd0);
    checkOutput("reset_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, ifc.done}, 32'd0);
    checkOutput("reset_lastcmd", {24'd0, ifc.lastCmd}, 32'h00);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    doneBefore = doneTotal;
    applyStimulus(8'h02, 24'h000005, 32'hDEADBEEF, 32, rdata, busyMid);
    checkOutput("write_done", doneTotal - doneBefore, 32'd1);
    checkOutput("write_lastcmd", {24'd0, ifc.lastCmd}, 32'h02);
    checkOutput("write_busy_mid", {31'd0, busyMid}, 32'd1);
    checkOutput("write_busy_after", {31'd0, ifc.busy}, 32'd0);

    doneBefore = doneTotal;
    applyStimulus(8'h03, 24'h000005, 32'd0, 32, rdata, busyMid);
    checkOutput("read5_data", rdata, 32'hDEADBEEF);
    checkOutput("read5_done", doneTotal - doneBefore, 32'd1);
    checkOutput("read5_busy_after", {31'd0, ifc.busy}, 32'd0);
    checkOutput("read5_miso_after", {31'd0, ifc.miso}, 32'd0);
    checkOutput("read5_lastcmd", {24'd0, ifc.lastCmd}, 32'h03);

    applyStimulus(8'h02, 24'h000013, 32'h12345678, 32, rdata, busyMid);
    applyStimulus(8'h03, 24'h000003, 32'd0, 32, rdata, busyMid);
    checkOutput("wrap_read3", rdata, 32'h12345678);

    applyStimulus(8'h02, 24'h000002, 32'hA5A5A5A5, 32, rdata, busyMid);
    doneBefore = doneTotal;
    applyStimulus(8'h02, 24'h000002, 32'h0F0F0F0F, 20, rdata, busyMid);
    checkOutput("abort_done", doneTotal - doneBefore, 32'd0);
    checkOutput("abort_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("abort_miso", {31'd0, ifc.miso}, 32'd0);
    applyStimulus(8'h03, 24'h000002, 32'd0, 32, rdata, busyMid);
    checkOutput("abort_read2", rdata, 32'hA5A5A5A5);

    misoOr     = 1'b0;
    doneBefore = doneTotal;
    applyStimulus(8'h9F, 24'hFFFFFF, 32'hFFFFFFFF, 32, rdata, busyMid);
    checkOutput("unknown_lastcmd", {24'd0, ifc.lastCmd}, 32'h9F);
    checkOutput("unknown_miso", {31'd0, misoOr}, 32'd0);
    checkOutput("unknown_done", doneTotal - doneBefore, 32'd0);
    applyStimulus(8'h03, 24'h000005, 32'd0, 32, rdata, busyMid);
    checkOutput("unknown_read5", rdata, 32'hDEADBEEF);

    // Bit 21 of DEADBEEF is 1, so miso is high when reset hits.
    ifc.cs = 1'b0;
    repeat (3) @(negedge clk);
    shiftBits(32'h03, 8, dummy);
    shiftBits(32'h000005, 24, dummy);
    shiftBits(32'd0, 10, dummy);
    repeat (3) @(negedge clk);
    checkOutput("rst_miso_before", {31'd0, ifc.miso}, 32'd1);
    rstN = 1'b0;
    #1;
    checkOutput("rst_miso", {31'd0, ifc.miso}, 32'd0);
    checkOutput("rst_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("rst_lastcmd", {24'd0, ifc.lastCmd}, 32'h00);
    @(negedge clk);
    ifc.cs = 1'b1;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    repeat (3) @(negedge clk);

    doneBefore = doneTotal;
    applyStimulus(8'h02, 24'h000007, 32'hCAFEF00D, 32, rdata, busyMid);
    applyStimulus(8'h03, 24'h000007, 32'd0, 32, rdata, busyMid);
    checkOutput("post_rst_read7", rdata, 32'hCAFEF00D);
    checkOutput("post_rst_done", doneTotal - doneBefore, 32'd2);
    applyStimulus(8'h03, 24'h000005, 32'd0, 32, rdata, busyMid);
    checkOutput("post_rst_read5", rdata, 32'hDEADBEEF);
    checkOutput("done_single_cycle", {31'd0, doubleDone}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
